// File: rtl/sig_storage_loop_if.sv
// BRAM fetch handshake between the signal storage loop and the upstream BRAM reader.
// The master side issues word requests; the slave side returns data with a valid strobe.
interface sig_storage_loop_if #(
   parameter int unsigned DATA_W = 32
);

   logic              request;
   logic              bramValid;
   logic [DATA_W-1:0] bramIn;

   modport master (
      output request,
      input  bramValid,
      input  bramIn
   );

   modport slave (
      input  request,
      output bramValid,
      output bramIn
   );

endinterface

// File: rtl/sig_storage_loop.sv
// Signal storage loop: prefetches a window of BRAM words into a local buffer and
// replays them through an independent, optionally looping, read pointer.
module sig_storage_loop #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned GAP_CYCLES = 3,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [AW-1:0]       baseAddr,
   input  logic [AW:0]         numFetches,
   input  logic                loopMode,
   input  logic                storeConfig,
   input  logic                fetch,
   sig_storage_loop_if.master  bram,
   input  logic                returnToBaseAddr,
   input  logic                incrementAddr,
   output logic [DATA_W-1:0]   playbackOut,
   output logic                fillDone,
   output logic                busy,
   output logic [AW-1:0]       wrPtrDBG,
   output logic [AW-1:0]       rdPtrDBG
);

   localparam int unsigned GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StGap  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [AW-1:0]     base_q;
   logic [AW:0]       fetches_q;
   logic              loop_q;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [AW:0]       count_inc;
   logic [GW-1:0]     gap_q, gap_d;
   logic              mem_we;

   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     win_end;
   logic              inc_prev_q;
   logic              inc_pulse;
   logic [DATA_W-1:0] play_q;

   logic [DATA_W-1:0] mem [DEPTH];

   assign count_inc = count_q + (AW+1)'(1);

   // Fill sequencer; dropping fetch outside IDLE always wins and discards any valid word.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      gap_d    = gap_q;
      mem_we   = 1'b0;
      if (state_q != StIdle && !fetch) begin
         state_d = StIdle;
         count_d = '0;
         gap_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fetch) begin
                  wr_ptr_d = base_q;
                  count_d  = '0;
                  gap_d    = '0;
                  state_d  = (fetches_q == '0) ? StDone : StReq;
               end
            end
            StReq: begin
               if (bram.bramValid) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = count_inc;
                  gap_d    = '0;
                  if (count_inc == fetches_q) begin
                     state_d = StDone;
                  end else if (GAP_CYCLES == 0) begin
                     state_d = StReq;
                  end else begin
                     state_d = StGap;
                  end
               end
            end
            StGap: begin
               if (gap_q == GapLast) begin
                  gap_d   = '0;
                  state_d = StReq;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
            StDone: begin
               state_d = StDone;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         gap_q     <= '0;
         base_q    <= '0;
         fetches_q <= '0;
         loop_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         if (storeConfig && state_q == StIdle) begin
            base_q    <= baseAddr;
            fetches_q <= numFetches;
            loop_q    <= loopMode;
         end
      end
   end

   // A full-depth window wraps its end to base-1, which the truncated add gives for free.
   assign win_end   = base_q + fetches_q[AW-1:0] - AW'(1);
   assign inc_pulse = incrementAddr & ~inc_prev_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      if (returnToBaseAddr) begin
         rd_ptr_d = base_q;
      end else if (inc_pulse) begin
         if (!loop_q) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else if (fetches_q == '0 || rd_ptr_q == win_end) begin
            rd_ptr_d = base_q;
         end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         inc_prev_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         inc_prev_q <= incrementAddr;
      end
   end

   // Buffer contents survive reset; only the write port touches the array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr_q] <= bram.bramIn;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         play_q <= '0;
      end else begin
         play_q <= mem[rd_ptr_q];
      end
   end

   assign bram.request = (state_q == StReq);
   assign busy         = (state_q == StReq) || (state_q == StGap);
   assign fillDone     = (state_q == StDone);
   assign playbackOut  = play_q;
   assign wrPtrDBG     = wr_ptr_q;
   assign rdPtrDBG     = rd_ptr_q;

endmodule

// File: tb/tb_sig_storage_loop.sv
// Randomised bench for sig_storage_loop: a gap-3 unit and a back-to-back unit share all
// control inputs and are checked against a transaction-level model of window, buffer and pointer.
module tb_sig_storage_loop;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_fetches;
   logic          loop_mode;
   logic          store_config;
   logic          fetch;
   logic          return_to_base;
   logic          increment_addr;

   logic [1:0][DW-1:0] play;
   logic [1:0]         done;
   logic [1:0]         busy;
   logic [1:0][AW-1:0] wr_dbg;
   logic [1:0][AW-1:0] rd_dbg;

   sig_storage_loop_if #(.DATA_W(DW)) bus0 ();
   sig_storage_loop_if #(.DATA_W(DW)) bus1 ();

   sig_storage_loop #(.DATA_W(DW), .DEPTH(DEPTH), .GAP_CYCLES(0)) u_dut0 (
      .clk              (clk),
      .reset            (reset),
      .baseAddr         (base_addr),
      .numFetches       (num_fetches),
      .loopMode         (loop_mode),
      .storeConfig      (store_config),
      .fetch            (fetch),
      .bram             (bus0),
      .returnToBaseAddr (return_to_base),
      .incrementAddr    (increment_addr),
      .playbackOut      (play[0]),
      .fillDone         (done[0]),
      .busy             (busy[0]),
      .wrPtrDBG         (wr_dbg[0]),
      .rdPtrDBG         (rd_dbg[0])
   );

   sig_storage_loop #(.DATA_W(DW), .DEPTH(DEPTH), .GAP_CYCLES(3)) u_dut1 (
      .clk              (clk),
      .reset            (reset),
      .baseAddr         (base_addr),
      .numFetches       (num_fetches),
      .loopMode         (loop_mode),
      .storeConfig      (store_config),
      .fetch            (fetch),
      .bram             (bus1),
      .returnToBaseAddr (return_to_base),
      .incrementAddr    (increment_addr),
      .playbackOut      (play[1]),
      .fillDone         (done[1]),
      .busy             (busy[1]),
      .wrPtrDBG         (wr_dbg[1]),
      .rdPtrDBG         (rd_dbg[1])
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: stored window, read position, per-unit buffer image and fill progress.
   int            m_base, m_n, m_rd;
   bit            m_loop, m_inc_prev, m_idle;
   int            m_wr [2];
   int            m_cnt [2];
   logic [DW-1:0] ref_mem [2][DEPTH];
   bit            ref_known [2][DEPTH];
   logic [DW-1:0] exp_play [2];
   bit            exp_known [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit req_of(input int w);
      return (w == 1) ? bus1.request : bus0.request;
   endfunction

   task automatic drive_bram(input int w, input logic v, input logic [DW-1:0] d);
      if (w == 1) begin
         bus1.bramValid = v;
         bus1.bramIn    = d;
      end else begin
         bus0.bramValid = v;
         bus0.bramIn    = d;
      end
   endtask

   function automatic int next_rd(input int rd);
      if (!m_loop) return (rd + 1) % DEPTH;
      if (m_n == 0) return m_base;
      if (rd == (m_base + m_n - 1) % DEPTH) return m_base;
      return (rd + 1) % DEPTH;
   endfunction

   // Apply the effect of the coming clock edge to the model, then wait for the next negedge.
   task automatic step();
      bit            req [2];
      bit            vld [2];
      logic [DW-1:0] din [2];
      req[0] = bus0.request;   req[1] = bus1.request;
      vld[0] = bus0.bramValid; vld[1] = bus1.bramValid;
      din[0] = bus0.bramIn;    din[1] = bus1.bramIn;
      for (int i = 0; i < 2; i++) begin
         exp_play[i]  = reset ? '0 : ref_mem[i][m_rd];
         exp_known[i] = reset || ref_known[i][m_rd];
      end
      if (reset) begin
         m_base = 0; m_n = 0; m_loop = 0; m_rd = 0; m_inc_prev = 0; m_idle = 1;
         for (int i = 0; i < 2; i++) begin
            m_wr[i]  = 0;
            m_cnt[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_idle && fetch && req[i] && vld[i] && m_cnt[i] < m_n) begin
               ref_mem[i][m_wr[i]]   = din[i];
               ref_known[i][m_wr[i]] = 1'b1;
               m_wr[i]  = (m_wr[i] + 1) % DEPTH;
               m_cnt[i] = m_cnt[i] + 1;
            end
         end
         if (return_to_base) m_rd = m_base;
         else if (increment_addr && !m_inc_prev) m_rd = next_rd(m_rd);
         if (m_idle && fetch) begin
            for (int i = 0; i < 2; i++) begin
               m_wr[i]  = m_base;
               m_cnt[i] = 0;
            end
         end
         if (m_idle && store_config) begin
            m_base = int'(base_addr);
            m_n    = int'(num_fetches);
            m_loop = loop_mode;
         end
         m_inc_prev = increment_addr;
         m_idle     = !fetch;
      end
      @(negedge clk);
   endtask

   task automatic store_cfg(input int b, input int n, input bit l);
      base_addr    = AW'(b);
      num_fetches  = (AW+1)'(n);
      loop_mode    = l;
      store_config = 1'b1;
      step();
      store_config = 1'b0;
   endtask

   // Raise fetch and answer requests of unit w; drop_at >= 0 drops fetch while offering that word.
   task automatic fill(input int w, input int n, input bit fixed, input bit rnd_wait,
                       input int drop_at);
      int            got = 0;
      int            lows = 0;
      int            budget = 0;
      logic [DW-1:0] d;
      fetch = 1'b1;
      step();
      check("fill_start_wr", wr_dbg[w], m_wr[w]);
      check("fill_start_req", req_of(w), 1);
      while (got < n && budget < 3000) begin
         budget++;
         if (req_of(w) && !(rnd_wait && $urandom_range(0, 3) == 0)) begin
            if (got > 0) check("gap_len", lows, (w == 1) ? 3 : 0);
            lows = 0;
            d = fixed ? DW'(32'hA0 + got) : DW'($urandom);
            drive_bram(w, 1'b1, d);
            if (got == drop_at) fetch = 1'b0;
            got++;
         end else begin
            if (!req_of(w)) lows++;
            drive_bram(w, 1'b0, '0);
         end
         step();
         if (!fetch) break;
      end
      drive_bram(w, 1'b0, '0);
      if (drop_at < 0) begin
         check("fill_count", got, n);
         check("fill_done", done[w], 1);
         check("fill_busy", busy[w], 0);
         check("fill_req", req_of(w), 0);
         check("fill_wr", wr_dbg[w], m_wr[w]);
      end
   endtask

   task automatic pb(input string tag, input int w, input bit ret);
      if (ret) return_to_base = 1'b1;
      else increment_addr = 1'b1;
      step();
      return_to_base = 1'b0;
      increment_addr = 1'b0;
      check({tag, "_rd"}, rd_dbg[w], m_rd);
      step();
      if (exp_known[w]) check({tag, "_data"}, play[w], exp_play[w]);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, n;
      bit l;
      reset = 1'b1; base_addr = '0; num_fetches = '0; loop_mode = 1'b0;
      store_config = 1'b0; fetch = 1'b0; return_to_base = 1'b0; increment_addr = 1'b0;
      drive_bram(0, 1'b0, '0);
      drive_bram(1, 1'b0, '0);
      @(negedge clk);
      step(); step();
      reset = 1'b0;
      step();
      for (int w = 0; w < 2; w++) begin
         check("rst_req", req_of(w), 0);
         check("rst_busy", busy[w], 0);
         check("rst_done", done[w], 0);
         check("rst_wr", wr_dbg[w], 0);
         check("rst_rd", rd_dbg[w], 0);
         check("rst_play", play[w], 0);
      end

      // Window 10..13 with fixed data, then looped playback.
      store_cfg(10, 4, 1);
      fill(1, 4, 1, 0, -1);
      step();
      check("done_hold", done[1], 1);
      fetch = 1'b0;
      step();
      check("done_clear", done[1], 0);
      pb("loop_ret", 1, 1);
      for (int i = 0; i < 6; i++) pb("loop_inc", 1, 0);

      // Back-to-back fill across the top of the buffer, linear playback wraps 255 -> 0.
      store_cfg(254, 4, 0);
      fill(0, 4, 0, 0, -1);
      check("wrap_wr", wr_dbg[0], 2);
      fetch = 1'b0;
      step();
      pb("wrap_ret", 0, 1);
      for (int i = 0; i < 3; i++) pb("wrap_inc", 0, 0);
      check("wrap_rd", rd_dbg[0], 1);

      // Abort after two words with a valid word in the dropping cycle, then restart.
      store_cfg(10, 4, 1);
      fill(1, 4, 0, 0, 2);
      check("abort_busy", busy[1], 0);
      check("abort_done", done[1], 0);
      check("abort_req", req_of(1), 0);
      check("abort_wr", wr_dbg[1], 12);
      pb("abort_ret", 1, 1);
      pb("abort_inc", 1, 0);
      pb("abort_inc", 1, 0);
      fill(1, 4, 0, 1, -1);
      fetch = 1'b0;
      step();
      pb("refill_ret", 1, 1);
      for (int i = 0; i < 4; i++) pb("refill_inc", 1, 0);

      // Empty window goes straight to DONE; config is frozen there.
      store_cfg(50, 0, 1);
      fetch = 1'b1;
      step();
      for (int w = 0; w < 2; w++) begin
         check("empty_done", done[w], 1);
         check("empty_req", req_of(w), 0);
         check("empty_busy", busy[w], 0);
      end
      store_cfg(77, 5, 0);
      check("empty_done_hold", done[1], 1);
      pb("empty_ret", 1, 1);
      check("empty_base", rd_dbg[1], 50);
      pb("empty_inc", 1, 0);
      check("empty_hold", rd_dbg[1], 50);
      fetch = 1'b0;
      step();

      // Full-depth fill on the back-to-back unit.
      store_cfg(100, DEPTH, 1);
      fill(0, DEPTH, 0, 0, -1);
      check("full_wr", wr_dbg[0], 100);
      fetch = 1'b0;
      step();
      pb("full_ret", 0, 1);
      for (int i = 0; i < 3; i++) pb("full_inc", 0, 0);

      // Random windows with random response latency.
      repeat (4) begin
         b = int'($urandom_range(0, DEPTH - 1));
         n = int'($urandom_range(1, 8));
         l = 1'($urandom_range(0, 1));
         store_cfg(b, n, l);
         fill(1, n, 0, 1, -1);
         fetch = 1'b0;
         step();
         pb("rnd_ret", 1, 1);
         for (int i = 0; i < n + 2; i++) pb("rnd_inc", 1, 0);
      end

      // Reset while in GAP, then a held increment advances exactly once.
      store_cfg(20, 4, 0);
      fetch = 1'b1;
      step();
      for (int i = 0; i < 10 && !req_of(1); i++) step();
      drive_bram(1, 1'b1, DW'($urandom));
      step();
      drive_bram(1, 1'b0, '0);
      check("gap_busy", busy[1], 1);
      check("gap_req", req_of(1), 0);
      reset = 1'b1;
      fetch = 1'b0;
      increment_addr = 1'b1;
      step();
      reset = 1'b0;
      check("gaprst_req", req_of(1), 0);
      check("gaprst_busy", busy[1], 0);
      check("gaprst_done", done[1], 0);
      check("gaprst_wr", wr_dbg[1], 0);
      check("gaprst_rd", rd_dbg[1], 0);
      check("gaprst_play", play[1], 0);
      repeat (5) step();
      increment_addr = 1'b0;
      step();
      check("held_inc_rd", rd_dbg[1], 1);
      check("held_inc_model", rd_dbg[1], m_rd);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
